// File: rtl/core_wb_pkg.sv
// Shared types and constants for the write-back arbiter / register scoreboard.
package core_wb_pkg;

  localparam int NUM_WB_SRC = 3;
  localparam int WB_XLEN    = 32;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_LSU = 2'd1,
    WB_SRC_MDU = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] value;
  } wb_req_t;

  // One-hot mask of a register id, used for pending set/clear.
  function automatic logic [31:0] reg_onehot(input logic [4:0] id);
    reg_onehot = 32'd1 << id;
  endfunction

endpackage

// File: rtl/core_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant searched from pointer p,
// pointer moves to (granted index + 1) mod N and holds on idle cycles.
module core_rr_arbiter #(
  parameter int N = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_any
);

  localparam logic [IDX_W:0]   N_W  = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic [IDX_W:0]   w_cand;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    w_gnt  = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand >= N_W) w_cand = w_cand - N_W;
      if (!w_any && i_req[w_cand[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_cand[IDX_W-1:0];
        w_gnt[w_cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

  // Advance the pointer past the winner; idle cycles keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_idx;
  assign o_gnt_any = w_any;

endmodule

// File: rtl/core_wb_scoreboard.sv
// Write-back port sharing plus register pending scoreboard.
// Requesters (0=ALU, 1=LSU, 2=MDU) compete round-robin for the single
// register-file write port; the winner is written one cycle later.
// A 32-bit pending vector marks registers with an outstanding write so
// EXEC can stall on RAW (rs busy) and WAW (issue_ready low).
// Optional macro CORE_WB_FORWARD_EN: forward the committing value to the
// source operands and drop busy in the commit cycle.
module core_wb_scoreboard
  import core_wb_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_SRC,
  parameter int XLEN    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][4:0]       req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_value,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [4:0]                    issue_rd,
  input  logic [4:0]                    rs_a_id,
  input  logic [4:0]                    rs_b_id,
  output logic                          rs_a_busy,
  output logic                          rs_b_busy,
  output logic                          fwd_a_en,
  output logic                          fwd_b_en,
  output logic [XLEN-1:0]               fwd_a_value,
  output logic [XLEN-1:0]               fwd_b_value,
  output logic                          reg_d_en,
  output logic                          reg_d_write,
  output logic [4:0]                    reg_d_id,
  output logic [XLEN-1:0]               reg_d_value
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_any;

  logic               r_wb_en;
  logic               r_wb_write;
  logic [4:0]         r_wb_id;
  logic [XLEN-1:0]    r_wb_value;

  logic [31:0]        r_pending;
  logic [31:0]        w_set;
  logic [31:0]        w_clr;
  logic               w_a_pend;
  logic               w_b_pend;

  core_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req_valid),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  assign req_ready = w_gnt;

  // Output stage: capture the granted rd/value, strobe the write next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en    <= 1'b0;
      r_wb_write <= 1'b0;
      r_wb_id    <= '0;
      r_wb_value <= '0;
    end else begin
      r_wb_en <= w_gnt_any;
      if (w_gnt_any) begin
        r_wb_write <= (req_rd[w_gnt_idx] != REG_X0);
        r_wb_id    <= req_rd[w_gnt_idx];
        r_wb_value <= req_value[w_gnt_idx];
      end else begin
        r_wb_write <= 1'b0;
      end
    end
  end

  assign reg_d_en    = r_wb_en;
  assign reg_d_write = r_wb_write;
  assign reg_d_id    = r_wb_id;
  assign reg_d_value = r_wb_value;

  // WAW stall: a second writer of a still-pending register must wait.
  assign issue_ready = !((issue_rd != REG_X0) && r_pending[issue_rd]);

  assign w_set = (issue_valid && issue_ready && (issue_rd != REG_X0))
               ? reg_onehot(issue_rd) : 32'd0;
  assign w_clr = r_wb_en ? reg_onehot(r_wb_id) : 32'd0;

  // Pending vector: clear on commit, then set on issue so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign w_a_pend = r_pending[rs_a_id] && (rs_a_id != REG_X0);
  assign w_b_pend = r_pending[rs_b_id] && (rs_b_id != REG_X0);

`ifdef CORE_WB_FORWARD_EN
  logic w_a_hit;
  logic w_b_hit;

  assign w_a_hit     = r_wb_en && r_wb_write && (r_wb_id == rs_a_id);
  assign w_b_hit     = r_wb_en && r_wb_write && (r_wb_id == rs_b_id);
  assign fwd_a_en    = w_a_hit;
  assign fwd_b_en    = w_b_hit;
  assign fwd_a_value = w_a_hit ? r_wb_value : '0;
  assign fwd_b_value = w_b_hit ? r_wb_value : '0;
  assign rs_a_busy   = w_a_pend && !w_a_hit;
  assign rs_b_busy   = w_b_pend && !w_b_hit;
`else
  assign fwd_a_en    = 1'b0;
  assign fwd_b_en    = 1'b0;
  assign fwd_a_value = '0;
  assign fwd_b_value = '0;
  assign rs_a_busy   = w_a_pend;
  assign rs_b_busy   = w_b_pend;
`endif

endmodule

// File: tb/tb_core_wb_scoreboard.sv
// Scoreboard bench for core_wb_scoreboard: expected register-file writes
// are queued as requests are granted; a monitor pops and compares on reg_d_en.
module tb_core_wb_scoreboard;

  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][4:0]      req_rd;
  logic [NUM_REQ-1:0][XLEN-1:0] req_value;
  logic                         issue_valid;
  logic                         issue_ready;
  logic [4:0]                   issue_rd;
  logic [4:0]                   rs_a_id, rs_b_id;
  logic                         rs_a_busy, rs_b_busy;
  logic                         fwd_a_en, fwd_b_en;
  logic [XLEN-1:0]              fwd_a_value, fwd_b_value;
  logic                         reg_d_en, reg_d_write;
  logic [4:0]                   reg_d_id;
  logic [XLEN-1:0]              reg_d_value;

  core_wb_scoreboard #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_value(req_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs_a_id(rs_a_id), .rs_b_id(rs_b_id),
    .rs_a_busy(rs_a_busy), .rs_b_busy(rs_b_busy),
    .fwd_a_en(fwd_a_en), .fwd_b_en(fwd_b_en),
    .fwd_a_value(fwd_a_value), .fwd_b_value(fwd_b_value),
    .reg_d_en(reg_d_en), .reg_d_write(reg_d_write),
    .reg_d_id(reg_d_id), .reg_d_value(reg_d_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      id;
    logic            wr;
    logic [XLEN-1:0] value;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [4:0] id, input logic [XLEN-1:0] v);
    exp_t e;
    e.id    = id;
    e.wr    = (id != 5'd0);
    e.value = v;
    q.push_back(e);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (reg_d_en === 1'b1) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_unexpected: got write id %0d value 0x%0h expected no write",
                   reg_d_id, reg_d_value);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wb_id", 64'(reg_d_id), 64'(e.id));
          check("wb_write", 64'(reg_d_write), 64'(e.wr));
          check("wb_value", 64'(reg_d_value), 64'(e.value));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_rd = '0; req_value = '0;
    issue_valid = 1'b0; issue_rd = 5'd0; rs_a_id = 5'd0; rs_b_id = 5'd0;
    repeat (2) tick();
    settle();
    check("rst_en", 64'(reg_d_en), 64'd0);
    check("rst_write", 64'(reg_d_write), 64'd0);
    check("rst_id", 64'(reg_d_id), 64'd0);
    check("rst_value", 64'(reg_d_value), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_fwd", 64'({fwd_a_en, fwd_b_en, rs_a_busy, rs_b_busy}), 64'd0);
    rst_n = 1'b1;

    // Three requesters from p=0: grants 0,1,2 in order.
    tick();
    req_valid = 3'b111;
    req_rd[0] = 5'd1; req_value[0] = 32'h11111111;
    req_rd[1] = 5'd2; req_value[1] = 32'h22222222;
    req_rd[2] = 5'd3; req_value[2] = 32'h33333333;
    settle();
    check("rr_grant0", 64'(req_ready), 64'b001); push(5'd1, 32'h11111111);
    tick(); req_valid[0] = 1'b0; settle();
    check("rr_grant1", 64'(req_ready), 64'b010); push(5'd2, 32'h22222222);
    tick(); req_valid[1] = 1'b0; settle();
    check("rr_grant2", 64'(req_ready), 64'b100); push(5'd3, 32'h33333333);
    tick(); req_valid[2] = 1'b0; settle();
    check("rr_idle", 64'(req_ready), 64'd0);

    // Pointer wrapped to 0: 0 beats 2.
    tick();
    req_valid = 3'b101;
    req_rd[0] = 5'd10; req_value[0] = 32'hA0A0A0A0;
    req_rd[2] = 5'd11; req_value[2] = 32'hB0B0B0B0;
    settle();
    check("ptr_wrap", 64'(req_ready), 64'b001); push(5'd10, 32'hA0A0A0A0);
    tick(); req_valid[0] = 1'b0; settle();
    check("ptr_wrap2", 64'(req_ready), 64'b100); push(5'd11, 32'hB0B0B0B0);
    tick(); req_valid = '0;

    // Single ALU write to a pending rd=5; busy through commit.
    issue_valid = 1'b1; issue_rd = 5'd5; settle();
    check("issue5_ready", 64'(issue_ready), 64'd1);
    tick(); issue_valid = 1'b0; rs_a_id = 5'd5; settle();
    check("busy5_pending", 64'(rs_a_busy), 64'd1);
    req_valid = 3'b001; req_rd[0] = 5'd5; req_value[0] = 32'hDEADBEEF; settle();
    check("alu_ready", 64'(req_ready), 64'b001); push(5'd5, 32'hDEADBEEF);
    tick(); req_valid = '0; settle();
`ifdef CORE_WB_FORWARD_EN
    check("busy5_commit", 64'(rs_a_busy), 64'd0);
    check("fwd5_en", 64'(fwd_a_en), 64'd1);
    check("fwd5_value", 64'(fwd_a_value), 64'hDEADBEEF);
`else
    check("busy5_commit", 64'(rs_a_busy), 64'd1);
    check("fwd5_en", 64'(fwd_a_en), 64'd0);
`endif
    tick(); settle();
    check("busy5_after", 64'(rs_a_busy), 64'd0);

    // Pointer now 1 and held over idle cycles: 2 beats 0.
    repeat (2) tick();
    req_valid = 3'b101;
    req_rd[0] = 5'd13; req_value[0] = 32'h13131313;
    req_rd[2] = 5'd14; req_value[2] = 32'h14141414;
    settle();
    check("ptr_hold", 64'(req_ready), 64'b100); push(5'd14, 32'h14141414);
    tick(); req_valid[2] = 1'b0; settle();
    check("ptr_hold2", 64'(req_ready), 64'b001); push(5'd13, 32'h13131313);
    tick(); req_valid = '0;

    // WAW stall on rd=7, independent rd=8 accepted.
    issue_valid = 1'b1; issue_rd = 5'd7; settle();
    check("issue7_ready", 64'(issue_ready), 64'd1);
    tick(); settle();
    check("issue7_waw", 64'(issue_ready), 64'd0);
    tick(); issue_rd = 5'd8; settle();
    check("issue8_ready", 64'(issue_ready), 64'd1);
    tick(); issue_valid = 1'b0; rs_a_id = 5'd7; rs_b_id = 5'd8; settle();
    check("busy7", 64'(rs_a_busy), 64'd1);
    check("busy8", 64'(rs_b_busy), 64'd1);
    req_valid = 3'b010; req_rd[1] = 5'd7; req_value[1] = 32'h70707070; settle();
    check("lsu7_ready", 64'(req_ready), 64'b010); push(5'd7, 32'h70707070);
    tick(); req_valid = '0; settle();
`ifdef CORE_WB_FORWARD_EN
    check("busy7_commit", 64'(rs_a_busy), 64'd0);
`else
    check("busy7_commit", 64'(rs_a_busy), 64'd1);
`endif
    tick(); issue_rd = 5'd7; settle();
    check("busy7_after", 64'(rs_a_busy), 64'd0);
    check("busy8_still", 64'(rs_b_busy), 64'd1);
    check("issue7_again", 64'(issue_ready), 64'd1);

    // x0: issue ignored, write strobed but not architecturally visible.
    tick(); issue_valid = 1'b1; issue_rd = 5'd0; rs_a_id = 5'd0; settle();
    check("issue_x0_ready", 64'(issue_ready), 64'd1);
    check("busy_x0", 64'(rs_a_busy), 64'd0);
    tick(); issue_valid = 1'b0;
    req_valid = 3'b010; req_rd[1] = 5'd0; req_value[1] = 32'h00001234; settle();
    check("lsu_x0_ready", 64'(req_ready), 64'b010); push(5'd0, 32'h00001234);
    tick(); req_valid = '0; settle();
    check("busy_x0_commit", 64'(rs_a_busy), 64'd0);
    check("fwd_x0", 64'(fwd_a_en), 64'd0);

    // MDU writes rd=9 while rs_b=9.
    tick(); issue_valid = 1'b1; issue_rd = 5'd9; settle();
    tick(); issue_valid = 1'b0; rs_b_id = 5'd9; settle();
    check("busy9", 64'(rs_b_busy), 64'd1);
    req_valid = 3'b100; req_rd[2] = 5'd9; req_value[2] = 32'hCAFE0001; settle();
    check("mdu9_ready", 64'(req_ready), 64'b100); push(5'd9, 32'hCAFE0001);
    tick(); req_valid = '0; settle();
`ifdef CORE_WB_FORWARD_EN
    check("busy9_commit", 64'(rs_b_busy), 64'd0);
    check("fwd9_en", 64'(fwd_b_en), 64'd1);
    check("fwd9_value", 64'(fwd_b_value), 64'hCAFE0001);
`else
    check("busy9_commit", 64'(rs_b_busy), 64'd1);
    check("fwd9_en", 64'(fwd_b_en), 64'd0);
`endif
    tick(); settle();
    check("busy9_after", 64'(rs_b_busy), 64'd0);

    // Write to non-pending rd=12; issue rd=12 in its commit cycle: set wins.
    req_valid = 3'b001; req_rd[0] = 5'd12; req_value[0] = 32'h0C0C0C0C; settle();
    check("alu12_ready", 64'(req_ready), 64'b001); push(5'd12, 32'h0C0C0C0C);
    tick(); req_valid = '0; issue_valid = 1'b1; issue_rd = 5'd12; rs_a_id = 5'd12; settle();
    check("issue12_ready", 64'(issue_ready), 64'd1);
    check("busy12_commit", 64'(rs_a_busy), 64'd0);
    tick(); issue_valid = 1'b0; settle();
    check("busy12_setwins", 64'(rs_a_busy), 64'd1);

    // Reset in the middle of a commit discards it and clears pending.
    req_valid = 3'b001; req_rd[0] = 5'd20; req_value[0] = 32'h20202020; settle();
    check("alu20_ready", 64'(req_ready), 64'b001);
    tick(); req_valid = '0;
    check("pre_reset_en", 64'(reg_d_en), 64'd1);
    rst_n = 1'b0; settle();
    check("midrst_en", 64'(reg_d_en), 64'd0);
    check("midrst_write", 64'(reg_d_write), 64'd0);
    check("midrst_id", 64'(reg_d_id), 64'd0);
    check("midrst_value", 64'(reg_d_value), 64'd0);
    check("midrst_busy", 64'(rs_a_busy), 64'd0);
    tick(); tick(); rst_n = 1'b1; settle();
    check("postrst_busy12", 64'(rs_a_busy), 64'd0);
    req_valid = 3'b101;
    req_rd[0] = 5'd22; req_value[0] = 32'h22220000;
    req_rd[2] = 5'd23; req_value[2] = 32'h23230000;
    settle();
    check("postrst_ptr0", 64'(req_ready), 64'b001); push(5'd22, 32'h22220000);
    tick(); req_valid[0] = 1'b0; settle();
    check("postrst_grant2", 64'(req_ready), 64'b100); push(5'd23, 32'h23230000);
    tick(); req_valid = '0;
    repeat (3) tick();
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_wb_scoreboard.md
Name: core_wb_scoreboard

Overview:
- Shares the single register-file write port among NUM_REQ write-back sources: ALU, LSU load return and MDU multi-cycle result.
- Tracks which architectural registers have a write outstanding, so the EXEC stage stalls on RAW/WAW hazards.
- Sits between the execution units and the register file, and drives its reg_d_* write port.

Parameters:
- NUM_REQ, 3, number of write-back requesters (index 0 = ALU, 1 = LSU, 2 = MDU).
- XLEN, 32, data width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a result
- req_ready  out  NUM_REQ  requester i granted this cycle
- req_rd  in  NUM_REQ x 5  destination register per requester
- req_value  in  NUM_REQ x XLEN  result per requester
- issue_valid  in  1  EXEC issues an instruction that writes rd
- issue_ready  out  1  issue accepted
- issue_rd  in  5  destination of the issuing instruction
- rs_a_id, rs_b_id  in  5 each  EXEC source registers
- rs_a_busy, rs_b_busy  out  1 each  source has a pending write
- fwd_a_en, fwd_b_en  out  1 each  forwarded value valid (optional feature)
- fwd_a_value, fwd_b_value  out  XLEN each  forwarded value
- reg_d_en  out  1  register-file write strobe
- reg_d_write  out  1  write is architecturally visible (0 for x0)
- reg_d_id  out  5  register-file write address
- reg_d_value  out  XLEN  register-file write data

Behaviour:
- Reset (async, rst_n=0):
  - pending[31:0] = 0; RR pointer = 0; output stage invalid.
  - reg_d_en = reg_d_write = 0; reg_d_id = 0; reg_d_value = 0.
  - All busy/fwd outputs = 0.
  - Mid-operation reset discards any in-flight write; requesters must re-present.
- Handshake:
  - Transfer when req_valid[i] & req_ready[i].
  - Requester must hold valid, rd and value stable until it is granted.
  - req_ready is combinational from req_valid and the pointer.
  - At most one grant per cycle; no grant when no valid request.
- Arbitration:
  - Round-robin starting at pointer p.
  - After grant to index g, p <= (g+1) mod NUM_REQ; p is unchanged on idle cycles.
- Output stage:
  - Grant in cycle t registers rd/value; reg_d_en = 1 for exactly cycle t+1.
  - reg_d_write = (rd != 0). Back-to-back grants give continuous reg_d_en.
  - Write latency is 1 cycle.
- Scoreboard:
  - issue_ready = ~(issue_rd != 0 & pending[issue_rd]), i.e. stall on WAW.
  - Accepted issue with rd != 0 sets pending[rd]; issue with rd = 0 is accepted and ignored.
  - pending[reg_d_id] clears at the end of a cycle where reg_d_en = 1.
  - Same-cycle set and clear of one rd: set wins.
  - A grant to a non-pending rd is legal and does not underflow.
- Busy:
  - rs_x_busy = pending[rs_x_id] & (rs_x_id != 0), combinational.
  - Without the optional feature, busy stays high through the commit cycle t+1 and drops in t+2, when the register file holds the value.

Optional Feature:
- Macro: CORE_WB_FORWARD_EN.
- With the macro:
  - In a cycle where reg_d_en & reg_d_write & reg_d_id == rs_x_id, fwd_x_en = 1 and fwd_x_value = reg_d_value.
  - rs_x_busy is forced 0 in that cycle, saving one stall cycle.
- Without the macro: fwd_* are tied to 0 and busy is as above.

Decomposition:
- Package core_wb_pkg holds:
  - NUM_WB_SRC = 3.
  - Enum wb_src_e {WB_SRC_ALU, WB_SRC_LSU, WB_SRC_MDU}.
  - Struct wb_req_t {rd[4:0], value[XLEN-1:0]}.
  - Localparam REG_X0 = 0.
- One sub-module, core_rr_arbiter: parameterized N-way round-robin with grant one-hot and pointer update.

Test Plan:
- Reset: assert rst_n=0 mid-grant -> all outputs 0 immediately, pending = 0, pointer = 0 after release.
- Single ALU req rd=5 value 0xDEADBEEF -> req_ready[0]=1 same cycle; next cycle reg_d_en=1, reg_d_write=1, id=5, value=0xDEADBEEF; pending[5] clears after.
- All three valid from p=0 with rd=1,2,3 -> grants 0,1,2 on consecutive cycles; reg_d_id 1,2,3 on the following cycles; p=0 afterwards.
- Issue rd=7, query rs_a=7 -> busy=1 until the cycle after commit. A second issue rd=7 while pending -> issue_ready=0; issue rd=8 -> issue_ready=1.
- x0: issue rd=0 -> pending unchanged; LSU req rd=0 value 0x1234 -> reg_d_en=1, reg_d_write=0; rs_a=0 busy=0.
- With CORE_WB_FORWARD_EN: MDU writes rd=9 value 0xCAFE0001 while rs_b=9 -> in the commit cycle fwd_b_en=1, fwd_b_value=0xCAFE0001, rs_b_busy=0. Without the macro -> busy=1 in that cycle, fwd_b_en=0.
